// File: rtl/camo_gate_bank_seq.sv
// Serially keyed bank of 2-input camouflaged gates with registered datapath.
// Optional even-parity key check: define CAMO_KEY_PARITY_EN.
module camo_gate_bank_seq #(
  parameter int NUM_GATES = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_start,
  input  logic                 key_in_valid,
  input  logic                 key_in_bit,
  output logic                 key_busy,
  output logic                 armed,
  output logic                 key_err,
  input  logic                 in_valid,
  input  logic [NUM_GATES-1:0] in_a,
  input  logic [NUM_GATES-1:0] in_b,
  output logic                 out_valid,
  output logic [NUM_GATES-1:0] out_y
);

  localparam int KEY_W = 2 * NUM_GATES;
  localparam int CNT_W = $clog2(KEY_W + 2);
`ifdef CAMO_KEY_PARITY_EN
  localparam int LOAD_BITS = KEY_W + 1;
`else
  localparam int LOAD_BITS = KEY_W;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LOAD_BITS - 1);

`ifdef CAMO_KEY_PARITY_EN
  typedef enum logic [1:0] {
    IDLE, LOAD, ARMED, ERR
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, LOAD, ARMED
  } state_t;
`endif

  state_t               state;
  logic [KEY_W-1:0]     key_sr;
  logic [KEY_W-1:0]     key_act;
  logic [KEY_W-1:0]     key_sr_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_GATES-1:0] y_f;

  always_comb begin
    key_sr_nxt = key_sr | (KEY_W'(key_in_bit) << cnt);
    y_f = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      unique case (1'b1)
        key_act[2*g]:
          y_f[g] = in_a[g] ^ in_b[g];
        !key_act[2*g] && !key_act[2*g+1]:
          y_f[g] = ~(in_a[g] & in_b[g]);
        !key_act[2*g] && key_act[2*g+1]:
          y_f[g] = ~(in_a[g] | in_b[g]);
        default:
          y_f[g] = 1'b0;
      endcase
    end
  end

`ifndef CAMO_KEY_PARITY_EN
  assign key_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_sr    <= '0;
      key_act   <= '0;
      cnt       <= '0;
      key_busy  <= 1'b0;
      armed     <= 1'b0;
`ifdef CAMO_KEY_PARITY_EN
      key_err   <= 1'b0;
`endif
      out_valid <= 1'b0;
      out_y     <= '0;
    end else begin
      // datapath sees the key that was active before this edge
      out_valid <= in_valid & armed;
      out_y     <= armed ? y_f : '0;
      if (key_start) begin
        state    <= LOAD;
        key_sr   <= '0;
        cnt      <= '0;
        key_busy <= 1'b1;
        armed    <= 1'b0;
`ifdef CAMO_KEY_PARITY_EN
        key_err  <= 1'b0;
`endif
      end else if (state == LOAD && key_in_valid) begin
        if (cnt == LAST) begin
          cnt      <= '0;
          key_busy <= 1'b0;
`ifdef CAMO_KEY_PARITY_EN
          if (key_in_bit == ^key_sr) begin
            key_act <= key_sr;
            state   <= ARMED;
            armed   <= 1'b1;
          end else begin
            state   <= ERR;
            key_err <= 1'b1;
          end
`else
          key_act <= key_sr_nxt;
          state   <= ARMED;
          armed   <= 1'b1;
`endif
        end else begin
          key_sr <= key_sr_nxt;
          cnt    <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_camo_gate_bank_seq.sv
// Directed bench for camo_gate_bank_seq (NUM_GATES=6).
// Follows CAMO_KEY_PARITY_EN the same way the design does.
module tb_camo_gate_bank_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_start;
  logic       key_in_valid;
  logic       key_in_bit;
  logic       key_busy;
  logic       armed;
  logic       key_err;
  logic       in_valid;
  logic [5:0] in_a;
  logic [5:0] in_b;
  logic       out_valid;
  logic [5:0] out_y;

  int n_chk  = 0;
  int n_pass = 0;

  camo_gate_bank_seq #(.NUM_GATES(6)) dut (
    .clk(clk), .rst(rst),
    .key_start(key_start),
    .key_in_valid(key_in_valid),
    .key_in_bit(key_in_bit),
    .key_busy(key_busy),
    .armed(armed),
    .key_err(key_err),
    .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid),
    .out_y(out_y)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b, input int gap);
    key_in_valid = 1'b1;
    key_in_bit   = b;
    tick();
    key_in_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  // start a load and shift in all 12 key bits, leaving the last one un-clocked
  task automatic load_body(input logic [11:0] k, input int gap);
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    check("busy_after_start", key_busy, 1);
    check("unarmed_in_load", armed, 0);
    for (int i = 0; i < 11; i++) send_bit(k[i], gap);
    key_in_valid = 1'b1;
    key_in_bit   = k[11];
`ifdef CAMO_KEY_PARITY_EN
    tick();
    key_in_bit = ^k;
`endif
  endtask

  task automatic load_key(input logic [11:0] k, input int gap);
    load_body(k, gap);
    tick();
    key_in_valid = 1'b0;
    check("armed_after_commit", armed, 1);
    check("busy_after_commit", key_busy, 0);
  endtask

  task automatic eval(input string tag, input logic [5:0] a,
                      input logic [5:0] b, input logic [5:0] exp);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick();
    in_valid = 1'b0;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_y"}, out_y, exp);
  endtask

  initial begin
    rst = 1'b1; key_start = 0; key_in_valid = 0; key_in_bit = 0;
    in_valid = 1'b1; in_a = 6'h3f; in_b = 6'h3f;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_armed", armed, 0);
    check("rst_busy", key_busy, 0);
    check("rst_err", key_err, 0);
    rst = 1'b0;
    tick();
    check("idle_drop_valid", out_valid, 0);
    check("idle_drop_y", out_y, 0);
    in_valid = 1'b0;

    // all-NAND key; input presented on the committing edge is dropped
    load_body(12'h000, 0);
    in_valid = 1'b1; in_a = 6'b111111; in_b = 6'b101010;
    tick();
    key_in_valid = 1'b0; in_valid = 1'b0;
    check("commit_armed", armed, 1);
    check("commit_drop", out_valid, 0);
    eval("nand", 6'b111111, 6'b101010, 6'b010101);

    load_key(12'h555, 0);
    eval("xor", 6'b110011, 6'b101010, 6'b011001);

    load_key(12'hAAA, 2);
    eval("nor", 6'b000011, 6'b000101, 6'b111000);

    // restart while armed: the concurrent input uses the old XOR key
    load_key(12'h555, 0);
    key_start = 1'b1;
    in_valid = 1'b1; in_a = 6'b110011; in_b = 6'b101010;
    tick();
    key_start = 1'b0; in_valid = 1'b0;
    check("restart_valid", out_valid, 1);
    check("restart_old_key", out_y, 6'b011001);
    check("restart_armed", armed, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    check("partial_armed", armed, 0);
    check("partial_busy", key_busy, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("partial_drop", out_valid, 0);
    check("partial_drop_y", out_y, 0);
    load_key(12'h000, 0);
    eval("reload_nand", 6'b111111, 6'b101010, 6'b010101);

    // reset mid-load
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", key_busy, 0);
    check("midrst_armed", armed, 0);
    in_valid = 1'b1; in_a = 6'h3f; in_b = 6'h00;
    tick();
    in_valid = 1'b0;
    check("midrst_valid", out_valid, 0);

`ifdef CAMO_KEY_PARITY_EN
    load_key(12'hAAA, 0);
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    for (int i = 0; i < 12; i++) send_bit(i == 0, 0);
    send_bit(1'b0, 0);
    check("par_err", key_err, 1);
    check("par_err_armed", armed, 0);
    check("par_err_busy", key_busy, 0);
    load_key(12'h001, 0);
    check("par_ok_err", key_err, 0);
    eval("par_ok", 6'b111111, 6'b101010, 6'b010101);
`else
    check("no_parity_err", key_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
